// File: rtl/csa_accumulator.sv
// csa_accumulator: frame accumulator that keeps the running sum in carry-save
// form (S, C) so each beat costs one 3:2 compression with no carry chain,
// then resolves S + C bit-serially (LSB first) before presenting the result.
module csa_accumulator #(
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_cnt
);

  localparam int STEP_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Single-bit majority, used for the serial resolve carry.
  function automatic logic maj_bit(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bitwise majority across the accumulator width, used for the CSA carry word.
  function automatic logic [ACC_W-1:0] maj_vec(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b,
                                               input logic [ACC_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    s_q, s_d;
  logic [ACC_W-1:0]    c_q, c_d;
  logic                cy_q, cy_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    x_s;

  assign x_s = {{(ACC_W-W){1'b0}}, in_data};

  // Next-state and datapath update for all three phases of a frame.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cy_d    = cy_q;
    step_d  = step_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCUM: begin
        // in_ready is always 1 here, so in_valid alone qualifies a beat.
        if (in_valid) begin
          s_d   = s_q ^ c_q ^ x_s;
          c_d   = maj_vec(s_q, c_q, x_s) << 1;
          cnt_d = cnt_q + 8'd1;
          if (in_last) begin
            state_d = RESOLVE;
            cy_d    = 1'b0;
            step_d  = {STEP_W{1'b0}};
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      RESOLVE: begin
        sum_d[step_q] = s_q[step_q] ^ c_q[step_q] ^ cy_q;
        cy_d          = maj_bit(s_q[step_q], c_q[step_q], cy_q);
        if (step_q == LAST_STEP) begin
          // Carry out of the top bit is dropped: result is modulo 2^ACC_W.
          state_d = DONE;
          step_d  = {STEP_W{1'b0}};
        end else begin
          step_d  = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          s_d     = {ACC_W{1'b0}};
          c_d     = {ACC_W{1'b0}};
          cy_d    = 1'b0;
          sum_d   = {ACC_W{1'b0}};
          cnt_d   = 8'd0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = ACCUM;
        s_d     = {ACC_W{1'b0}};
        c_d     = {ACC_W{1'b0}};
        cy_d    = 1'b0;
        step_d  = {STEP_W{1'b0}};
        sum_d   = {ACC_W{1'b0}};
        cnt_d   = 8'd0;
      end
    endcase
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s_q         <= {ACC_W{1'b0}};
      c_q         <= {ACC_W{1'b0}};
      cy_q        <= 1'b0;
      step_q      <= {STEP_W{1'b0}};
      sum_q       <= {ACC_W{1'b0}};
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cy_q        <= cy_d;
      step_q      <= step_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: hand-computed sums, latency, handshake,
// backpressure and mid-resolve reset behaviour.
module tb_csa_accumulator;

  localparam int W     = 4;
  localparam int ACC_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_cnt;

  int total_cnt;
  int bad_cnt;

  csa_accumulator #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one beat across a rising edge; called and returns at a falling edge.
  task automatic beat(input logic [W-1:0] d, input logic last);
    chk("in_ready_on_beat", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for out_valid after the last accept; check latency and the result.
  // noise=1 drives in_valid/in_last pulses during RESOLVE that must be ignored.
  task automatic wait_result(input logic [7:0] exp_sum, input logic [7:0] exp_cnt,
                             input logic noise);
    int cyc;
    cyc = 0;
    chk("no_valid_after_last", {31'd0, out_valid}, 32'd0);
    while (!out_valid && cyc < 20) begin
      if (noise) begin
        in_valid = cyc[0];
        in_last  = 1'b1;
        in_data  = 4'hF;
        chk("in_ready_resolve", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency", cyc, 32'd8);
    chk("out_sum", {24'd0, out_sum}, {24'd0, exp_sum});
    chk("out_cnt", {24'd0, out_cnt}, {24'd0, exp_cnt});
  endtask

  // Called right after wait_result with out_ready=1 held: check the clear.
  task automatic check_cleared();
    @(negedge clk);
    chk("valid_cleared", {31'd0, out_valid}, 32'd0);
    chk("ready_back", {31'd0, in_ready}, 32'd1);
    chk("sum_cleared", {24'd0, out_sum}, 32'd0);
    chk("cnt_cleared", {24'd0, out_cnt}, 32'd0);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
    chk("rst_out_cnt", {24'd0, out_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three beats of F: 45 = 0x2D.
    beat(4'hF, 1'b0);
    beat(4'hF, 1'b0);
    beat(4'hF, 1'b1);
    wait_result(8'h2D, 8'd3, 1'b0);
    check_cleared();

    // Single beat.
    beat(4'h7, 1'b1);
    wait_result(8'h07, 8'd1, 1'b0);
    check_cleared();

    // 18 back-to-back beats of F: 270 mod 256 = 0x0E.
    for (int i = 0; i < 18; i++) begin
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 4'hF;
      in_last  = (i == 17);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_result(8'h0E, 8'h12, 1'b0);
    check_cleared();

    // Backpressure with ignored beats during RESOLVE and DONE: 5+A = 0x0F.
    out_ready = 1'b0;
    beat(4'h5, 1'b0);
    beat(4'hA, 1'b1);
    wait_result(8'h0F, 8'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 4'h3;
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {24'd0, out_sum}, 32'h0F);
      chk("bp_cnt", {24'd0, out_cnt}, 32'd2);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    check_cleared();
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b1);
    wait_result(8'h07, 8'd2, 1'b0);
    check_cleared();

    // Reset at resolve step 3 aborts the frame with no out_valid.
    beat(4'h9, 1'b0);
    beat(4'h6, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {24'd0, out_sum}, 32'd0);
    chk("mid_rst_cnt", {24'd0, out_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b1);
    wait_result(8'h03, 8'd2, 1'b0);
    check_cleared();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameters SHALL be, one per line:
- W, 4, operand width in bits.
- ACC_W, 8, accumulator/result width in bits; ACC_W >= W+1.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  W  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  marks the final operand of a frame; qualified by in_valid.
- out_valid  output  1  resolved result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  binary sum of the frame, modulo 2^ACC_W.
- out_cnt  output  8  number of operands accepted in the frame, modulo 256.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset (rst_n); clk and rst_n are the only clock/reset ports.

Function
REQ-004 The block SHALL have three states: ACCUM, RESOLVE, DONE.
REQ-005 In ACCUM, in_ready SHALL be 1; in RESOLVE and DONE it SHALL be 0.
REQ-006 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1; in_data/in_last SHALL be ignored otherwise.
REQ-007 Internal redundant state SHALL be two ACC_W-bit registers, S and C, both 0 at frame start.
REQ-008 On each accepted beat, with X = zero-extended in_data, the block SHALL perform one 3:2 compression: S <= S^C^X; C <= (maj(S,C,X) << 1), with the bit shifted out of C[ACC_W-1] discarded (modulo 2^ACC_W).
REQ-009 No carry propagation SHALL occur during ACCUM; one beat per cycle back-to-back SHALL be sustained.
REQ-010 On each accepted beat, out_cnt SHALL increment by 1, wrapping 255 -> 0.
REQ-011 An accepted beat with in_last=1 SHALL be compressed like any other beat, and the state SHALL move ACCUM -> RESOLVE on that edge.
REQ-012 RESOLVE SHALL last exactly ACC_W cycles, bit-serial LSB first, with a carry flop cleared on RESOLVE entry.
REQ-013 At RESOLVE step i (0..ACC_W-1), the block SHALL set out_sum[i] = S[i]^C[i]^cy and cy = maj(S[i],C[i],cy).
REQ-014 The final carry out of bit ACC_W-1 SHALL be discarded.
REQ-015 After the edge computing bit ACC_W-1, the state SHALL be DONE with out_valid=1; out_valid therefore rises ACC_W cycles after the in_last accept edge.
REQ-016 In DONE, out_valid SHALL stay 1, and out_sum/out_cnt SHALL be held stable until a rising edge with out_ready=1.
REQ-017 On that edge, S, C, out_cnt and out_sum SHALL clear to 0, out_valid SHALL go to 0, and the state SHALL return to ACCUM (in_ready=1 the next cycle).
REQ-018 out_ready SHALL be ignored outside DONE.
REQ-019 out_valid SHALL be 0 in ACCUM and RESOLVE.
REQ-020 in_valid/in_last asserted in RESOLVE or DONE SHALL have no effect and SHALL NOT be queued.
REQ-021 out_sum SHALL equal (sum of all accepted operands of the frame) mod 2^ACC_W for any operand count, including counts above 256.

Reset
REQ-022 While rst_n=0, the block SHALL be in state ACCUM with S=0, C=0, carry flop 0, out_sum=0, out_cnt=0, out_valid=0, in_ready=1.
REQ-023 Reset asserted in any state, including mid-RESOLVE or in DONE with out_valid=1, SHALL abort the frame immediately with no out_valid pulse; the first beat after release starts a new frame.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Beats 4'hF, 4'hF, 4'hF (last on third), out_ready=1 -> out_valid exactly 8 cycles after third accept; out_sum=8'h2D; out_cnt=3.
- Single beat 4'h7 with in_last -> out_sum=8'h07, out_cnt=1; in_ready back to 1 one cycle after out handshake.
- 18 back-to-back beats of 4'hF, in_last on 18th -> out_sum=8'h0E (270 mod 256), out_cnt=8'h12; in_ready held 1 through all 18 cycles.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_cnt stable, in_ready=0; in_valid pulses with in_last during RESOLVE/DONE are ignored and the next frame's sum is unaffected.
- Reset mid-RESOLVE (rst_n low 1 cycle at step 3) -> outputs per REQ-022 immediately, no out_valid; next frame 4'h1, 4'h2 (last) -> out_sum=8'h03, out_cnt=2.
